// File: rtl/operand_entry_ctrl.sv
// ---------------------------------------------------------------------------
// operand_entry_ctrl
//
// Purpose:
//   Lets a user load two 8-bit operands from slide switches and step through
//   an operation select by using two push-buttons. Each button is
//   synchronized and debounced. Each clean press is turned into a
//   single-cycle pulse.
//   A three-state FSM steers LoadKey presses:
//     WAIT_A: the press loads Ain.
//     WAIT_B: the press loads Bin.
//     SHOW:   the press returns the FSM to WAIT_A.
//   Every operand load produces a one-cycle strobe E on the following edge.
//   OpKey presses step Operation modulo 4 in any state.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable cycles before a key level change is
//                    accepted (2..65535)
//
// Ports:
//   clk_i          system clock, rising-edge active
//   rst_i          asynchronous active-high reset
//   switches_i     [7:0] operand value from slide switches
//   load_key_i     raw bouncy LoadKey button, active-high
//   op_key_i       raw bouncy OpKey button, active-high
//   ain_o          [7:0] registered operand A
//   bin_o          [7:0] registered operand B
//   sel_o          registered operand select (0 = A, 1 = B)
//   e_o            registered one-cycle load strobe
//   operation_o    [1:0] registered operation select
//   state_o        [1:0] current FSM state (WAIT_A=00, WAIT_B=01, SHOW=10)
// ---------------------------------------------------------------------------
module operand_entry_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] switches_i,
  input  logic       load_key_i,
  input  logic       op_key_i,
  output logic [7:0] ain_o,
  output logic [7:0] bin_o,
  output logic       sel_o,
  output logic       e_o,
  output logic [1:0] operation_o,
  output logic [1:0] state_o
);

  localparam int DATA_W = 8;
  localparam int NKEYS  = 2;
  localparam int KEY_LD = 0;
  localparam int KEY_OP = 1;

  // The counter only has to reach DEBOUNCE_CYCLES-1. At that value, the
  // next differing edge is the accepting one.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_A  = 2'b00,
    WAIT_B  = 2'b01,
    SHOW    = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  // -------------------------------------------------------------------------
  // Key conditioning state (index 0 = LoadKey, index 1 = OpKey)
  // -------------------------------------------------------------------------
  logic [NKEYS-1:0]            sync1_q;
  logic [NKEYS-1:0]            sync2_q;
  logic [NKEYS-1:0]            deb_q;
  logic [NKEYS-1:0]            deb_d;
  logic [NKEYS-1:0]            deb_dly_q;
  logic [NKEYS-1:0][CNT_W-1:0] cnt_q;
  logic [NKEYS-1:0][CNT_W-1:0] cnt_d;
  logic [NKEYS-1:0]            press;

  // -------------------------------------------------------------------------
  // Control / datapath state
  // -------------------------------------------------------------------------
  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] ain_q;
  logic [DATA_W-1:0] ain_d;
  logic [DATA_W-1:0] bin_q;
  logic [DATA_W-1:0] bin_d;
  logic              sel_q;
  logic              sel_d;
  logic              pend_q;
  logic              pend_d;
  logic              e_q;
  logic [1:0]        op_q;
  logic [1:0]        op_d;

  // -------------------------------------------------------------------------
  // Synchronizers: two flops per key before anything else looks at them
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {op_key_i, load_key_i};
      sync2_q <= sync1_q;
    end
  end

  // -------------------------------------------------------------------------
  // Debounce
  //
  // The counter runs only while the synchronized level disagrees with the
  // debounced level. Any agreement clears it, so a bounce shorter than
  // DEBOUNCE_CYCLES never reaches the accept point.
  // -------------------------------------------------------------------------
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int k = 0; k < NKEYS; k++) begin
      if (sync2_q[k] == deb_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == CNT_LAST) begin
        deb_d[k] = sync2_q[k];
        cnt_d[k] = '0;
      end else begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      deb_q     <= '0;
      deb_dly_q <= '0;
      cnt_q     <= '0;
    end else begin
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      cnt_q     <= cnt_d;
    end
  end

  // Rising edge of the debounced level only; releases produce nothing.
  assign press = deb_q & ~deb_dly_q;

  // -------------------------------------------------------------------------
  // FSM, next-state and register updates
  //
  // Switches are sampled directly on the load edge. The operator sets the
  // switches well before pressing the key, and the key path adds
  // DEBOUNCE_CYCLES+2 cycles of settling, so the value is static here.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ain_d   = ain_q;
    bin_d   = bin_q;
    sel_d   = sel_q;
    pend_d  = 1'b0;
    op_d    = op_q;

    case (state_q)
      WAIT_A: begin
        if (press[KEY_LD]) begin
          ain_d   = switches_i;
          sel_d   = 1'b0;
          pend_d  = 1'b1;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (press[KEY_LD]) begin
          bin_d   = switches_i;
          sel_d   = 1'b1;
          pend_d  = 1'b1;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (press[KEY_LD]) begin
          state_d = WAIT_A;
        end
      end
      default: begin
        // The unused encoding recovers to WAIT_A on the next edge.
        state_d = WAIT_A;
      end
    endcase

    // OpKey acts independently of the FSM, so it can coincide with a load.
    if (press[KEY_OP]) begin
      op_d = op_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= WAIT_A;
    end else begin
      state_q <= state_d;
    end
  end

  // pend_q marks "an operand was loaded on the previous edge".
  // E is that mark delayed by one more edge. As a result, Sel and the operand
  // are already stable for a full cycle before E rises.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ain_q  <= '0;
      bin_q  <= '0;
      sel_q  <= 1'b0;
      pend_q <= 1'b0;
      e_q    <= 1'b0;
      op_q   <= 2'b00;
    end else begin
      ain_q  <= ain_d;
      bin_q  <= bin_d;
      sel_q  <= sel_d;
      pend_q <= pend_d;
      e_q    <= pend_q;
      op_q   <= op_d;
    end
  end

  assign ain_o       = ain_q;
  assign bin_o       = bin_q;
  assign sel_o       = sel_q;
  assign e_o         = e_q;
  assign operation_o = op_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// ---------------------------------------------------------------------------
// tb_operand_entry_ctrl
//
// Directed testbench for operand_entry_ctrl with DEBOUNCE_CYCLES = 4.
//
// Two scoreboard queues hold the hand-computed expected results:
//   exp_q  expected {Ain, Bin, Sel, State}, popped whenever E is seen high.
//   opx_q  expected Operation values, popped whenever Operation changes.
// Stimulus pushes into these queues when it issues a press. A separate
// monitor, running on the falling edge, pops entries and compares them.
// Timing-sensitive points (load edge, E edge, reset behaviour) are checked
// directly by the stimulus process.
// ---------------------------------------------------------------------------
module tb_operand_entry_ctrl;

  localparam int unsigned DB = 4;

  logic       clk;
  logic       rst;
  logic [7:0] switches;
  logic       load_key;
  logic       op_key;
  logic [7:0] ain;
  logic [7:0] bin;
  logic       sel;
  logic       e;
  logic [1:0] operation;
  logic [1:0] state;

  typedef struct packed {
    logic [7:0] ain;
    logic [7:0] bin;
    logic       sel;
    logic [1:0] state;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] opx_q[$];
  logic [1:0] prev_op;

  int checks;
  int failures;

  operand_entry_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .switches_i (switches),
    .load_key_i (load_key),
    .op_key_i   (op_key),
    .ain_o      (ain),
    .bin_o      (bin),
    .sel_o      (sel),
    .e_o        (e),
    .operation_o(operation),
    .state_o    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Returns one time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_load(input int hold);
    load_key = 1'b1;
    repeat (hold) tick();
    load_key = 1'b0;
    repeat (10) tick();
  endtask

  task automatic press_op();
    op_key = 1'b1;
    repeat (10) tick();
    op_key = 1'b0;
    repeat (10) tick();
  endtask

  // -------------------------------------------------------------------------
  // Monitor / scoreboard
  // -------------------------------------------------------------------------
  initial prev_op = 2'b00;

  always @(negedge clk) begin
    exp_t x;
    logic [1:0] xo;
    if (e === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_E: got E=1 expected no strobe (t=%0t)", $time);
      end else begin
        x = exp_q.pop_front();
        chk("E_ain",   32'(ain),   32'(x.ain));
        chk("E_bin",   32'(bin),   32'(x.bin));
        chk("E_sel",   32'(sel),   32'(x.sel));
        chk("E_state", 32'(state), 32'(x.state));
      end
    end
    if (rst === 1'b1) begin
      prev_op = 2'b00;
    end else if (operation !== prev_op) begin
      if (opx_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_op: got %0h expected %0h (t=%0t)", operation, prev_op, $time);
      end else begin
        xo = opx_q.pop_front();
        chk("op_step", 32'(operation), 32'(xo));
      end
      prev_op = operation;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    switches = 8'h00;
    load_key = 1'b0;
    op_key   = 1'b0;
    repeat (2) tick();

    // Reset state
    chk("rst_ain",   32'(ain),       32'h00);
    chk("rst_bin",   32'(bin),       32'h00);
    chk("rst_sel",   32'(sel),       32'h0);
    chk("rst_e",     32'(e),         32'h0);
    chk("rst_op",    32'(operation), 32'h0);
    chk("rst_state", 32'(state),     32'h0);
    rst = 1'b0;
    repeat (3) tick();

    // First press loads A: Ain at edge DB+2 = 6, E only at edge 7
    switches = 8'h2A;
    exp_q.push_back('{ain: 8'h2A, bin: 8'h00, sel: 1'b0, state: 2'b01});
    load_key = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 5) begin
        chk("ain_before_edge6", 32'(ain), 32'h00);
        chk("state_before_edge6", 32'(state), 32'h0);
      end
      if (k == 6) begin
        chk("ain_at_edge6", 32'(ain), 32'h2A);
        chk("sel_at_edge6", 32'(sel), 32'h0);
        chk("e_low_edge6", 32'(e), 32'h0);
        chk("state_edge6", 32'(state), 32'h1);
      end
      if (k == 7) chk("e_high_edge7", 32'(e), 32'h1);
      if (k == 8) chk("e_low_edge8", 32'(e), 32'h0);
    end
    load_key = 1'b0;
    repeat (10) tick();

    // Second press loads B; the third press only returns to WAIT_A
    switches = 8'hC3;
    exp_q.push_back('{ain: 8'h2A, bin: 8'hC3, sel: 1'b1, state: 2'b10});
    press_load(20);
    chk("show_state", 32'(state), 32'h2);
    switches = 8'h5A;
    press_load(20);
    chk("third_state", 32'(state), 32'h0);
    chk("third_ain",   32'(ain),   32'h2A);
    chk("third_bin",   32'(bin),   32'hC3);
    chk("third_sel",   32'(sel),   32'h1);

    // Bounce shorter than DB, plus a switch change: nothing may move
    switches = 8'h55;
    for (int k = 0; k < 15; k++) begin
      load_key = ~load_key;
      repeat (2) tick();
    end
    load_key = 1'b0;
    repeat (10) tick();
    chk("bounce_ain",   32'(ain),   32'h2A);
    chk("bounce_bin",   32'(bin),   32'hC3);
    chk("bounce_state", 32'(state), 32'h0);

    // Five OpKey presses: 01,10,11,00,01
    opx_q.push_back(2'b01);
    opx_q.push_back(2'b10);
    opx_q.push_back(2'b11);
    opx_q.push_back(2'b00);
    opx_q.push_back(2'b01);
    for (int k = 0; k < 5; k++) press_op();
    chk("op_final",    32'(operation), 32'h1);
    chk("op_state",    32'(state),     32'h0);
    chk("op_ain",      32'(ain),       32'h2A);
    chk("op_bin",      32'(bin),       32'hC3);

    // Simultaneous OpKey and LoadKey in WAIT_A
    switches = 8'h77;
    exp_q.push_back('{ain: 8'h77, bin: 8'hC3, sel: 1'b0, state: 2'b01});
    opx_q.push_back(2'b10);
    load_key = 1'b1;
    op_key   = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 6) begin
        chk("both_ain_edge6", 32'(ain),       32'h77);
        chk("both_op_edge6",  32'(operation), 32'h2);
        chk("both_e_edge6",   32'(e),         32'h0);
      end
      if (k == 7) chk("both_e_edge7", 32'(e), 32'h1);
    end
    load_key = 1'b0;
    op_key   = 1'b0;
    repeat (10) tick();

    // Walk to WAIT_A again: load B, then leave SHOW
    switches = 8'h11;
    exp_q.push_back('{ain: 8'h77, bin: 8'h11, sel: 1'b1, state: 2'b10});
    press_load(20);
    press_load(20);
    chk("pre_rst_state", 32'(state), 32'h0);

    // Reset one edge after an Ain load, while E is pending
    switches = 8'hE5;
    load_key = 1'b1;
    repeat (7) tick();
    chk("pend_ain", 32'(ain), 32'hE5);
    #2;
    rst = 1'b1;
    #1;
    chk("async_ain",   32'(ain),       32'h00);
    chk("async_bin",   32'(bin),       32'h00);
    chk("async_sel",   32'(sel),       32'h0);
    chk("async_e",     32'(e),         32'h0);
    chk("async_op",    32'(operation), 32'h0);
    chk("async_state", 32'(state),     32'h0);
    repeat (3) tick();
    chk("in_rst_e", 32'(e), 32'h0);
    // The key held through release must give exactly one press
    exp_q.push_back('{ain: 8'hE5, bin: 8'h00, sel: 1'b0, state: 2'b01});
    rst = 1'b0;
    repeat (20) tick();
    load_key = 1'b0;
    repeat (10) tick();
    chk("held_ain",   32'(ain),   32'hE5);
    chk("held_state", 32'(state), 32'h1);

    chk("exp_q_drained",  32'(exp_q.size()), 32'd0);
    chk("opx_q_drained",  32'(opx_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_entry_ctrl.md
OPERAND_ENTRY_CTRL -- requirements
Module: operand_entry_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required before a key level change is accepted; legal range 2..65535.
REQ-002 Clock  input  1  single system clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 Switches  input  8  operand value from slide switches; asynchronous to Clock.
REQ-005 LoadKey  input  1  raw, bouncy, active-high push-button; requests operand load.
REQ-006 OpKey  input  1  raw, bouncy, active-high push-button; steps the operation select.
REQ-007 Ain  output  8  registered operand A, to the downstream Ain port.
REQ-008 Bin  output  8  registered operand B, to the downstream Bin port.
REQ-009 Sel  output  1  registered operand select: 0 = A, 1 = B.
REQ-010 E  output  1  registered one-cycle load strobe.
REQ-011 Operation  output  2  registered operation select, to the downstream Operation port.
REQ-012 State  output  2  current FSM state encoding, for status LEDs.

Function
REQ-013 Each key SHALL pass through its own 2-flop synchronizer before any other logic uses it.
REQ-014 Debounce, per key:
- Counter clears whenever the synchronized level equals the debounced level.
- Counter increments whenever the two levels differ.
- On the DEBOUNCE_CYCLES-th consecutive differing edge, the debounced level takes the synchronized value and the counter clears.
REQ-015 Any bounce shorter than DEBOUNCE_CYCLES SHALL leave the debounced level unchanged.
REQ-016 A press pulse SHALL be a 0->1 transition of the debounced level, detected against a one-cycle-delayed copy; the pulse is high for exactly one cycle; releases generate nothing.
REQ-017 FSM states and encodings: WAIT_A=2'b00, WAIT_B=2'b01, SHOW=2'b10; 2'b11 is illegal and returns to WAIT_A on the next edge.
REQ-018 WAIT_A + LoadKey press, same edge: Ain<=Switches, Sel<=0, state<=WAIT_B.
REQ-019 WAIT_B + LoadKey press, same edge: Bin<=Switches, Sel<=1, state<=SHOW.
REQ-020 SHOW + LoadKey press: state<=WAIT_A; Ain, Bin and Sel unchanged; no E pulse.
REQ-021 E SHALL go high on the edge after each Ain or Bin load, for exactly one cycle; Sel and the loaded operand are stable the cycle before, during and after E.
REQ-022 Clean LoadKey, first sampled high at edge 0:
- Operand register updates at edge DEBOUNCE_CYCLES+2.
- E rises at edge DEBOUNCE_CYCLES+3.
REQ-023 OpKey press in any state: Operation increments modulo 4 (2'b11 -> 2'b00); FSM state and operands unaffected.
REQ-024 LoadKey and OpKey presses on the same edge SHALL both take effect.
REQ-025 Ain, Bin, Sel and Operation SHALL hold their values until explicitly changed; Switches changes alone SHALL never alter outputs.
REQ-026 A key held through reset release SHALL be debounced from level 0 and therefore produce one press once it has been stable for DEBOUNCE_CYCLES.

Reset
REQ-027 On Reset assertion, immediately:
- Ain=0, Bin=0, Sel=0, E=0, Operation=2'b00, State=WAIT_A.
- All synchronizer, debounce-counter, debounced-level and delayed-copy flops = 0.
REQ-028 Reset asserted while a strobe is pending or active SHALL force E low immediately; no E pulse follows reset release.

Verification
REQ-029 DEBOUNCE_CYCLES=4, Switches=8'h2A, clean LoadKey held 20 cycles -> Ain=8'h2A at edge 6, Sel=0, E high only at edge 7, State=2'b01.
REQ-030 Then Switches=8'hC3, second clean LoadKey press -> Bin=8'hC3, Sel=1, single E pulse, State=2'b10, Ain still 8'h2A; third press -> State=2'b00, no E.
REQ-031 LoadKey toggling every 2 cycles for 30 cycles, then low -> no E pulse, Ain/Bin/State unchanged.
REQ-032 Five clean OpKey presses -> Operation sequence 01,10,11,00,01; State and operands unchanged throughout.
REQ-033 OpKey and LoadKey pressed simultaneously in WAIT_A -> Operation increments and Ain loads on the same edge; E follows one edge later.
REQ-034 Reset asserted mid-cycle one edge after an Ain load (E pending) -> all outputs 0 at once, E never asserts; LoadKey held through release -> exactly one press after debounce.
